// File: rtl/move_select.sv
// Move selector: collects scored board candidates over one round and reports
// the first highest-scoring legal, unoccupied cell together with an accept count.
module move_select #(
    parameter int BOARD_W = 15,
    parameter int SCORE_W = 25
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_valid,
    input  logic [3:0]         i_row,
    input  logic [3:0]         i_col,
    input  logic               i_occupied,
    input  logic [SCORE_W-1:0] i_score,
    input  logic               i_last,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_found,
    output logic [3:0]         o_best_row,
    output logic [3:0]         o_best_col,
    output logic [SCORE_W-1:0] o_best_score,
    output logic [7:0]         o_count
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [4:0] BOARD_LIM = 5'(BOARD_W);

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               found_q;
    logic [3:0]         row_q;
    logic [3:0]         col_q;
    logic [SCORE_W-1:0] score_q;
    logic [7:0]         count_q;
    logic [7:0]         count_d;
    logic               accept;
    logic               better;

    always_comb begin
        accept  = i_valid && !i_occupied &&
                  ({1'b0, i_row} < BOARD_LIM) && ({1'b0, i_col} < BOARD_LIM);
        // Strict compare keeps the earlier candidate on a tie.
        better  = !found_q || (i_score > score_q);
        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            row_q   <= 4'hF;
            col_q   <= 4'hF;
            score_q <= '0;
            count_q <= '0;
        end else if (i_start && state_q != DONE) begin
            // A start in COLLECT restarts the round exactly like a fresh one.
            state_q <= COLLECT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            found_q <= 1'b0;
            row_q   <= 4'hF;
            col_q   <= 4'hF;
            score_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                COLLECT: begin
                    if (accept) begin
                        count_q <= count_d;
                        if (better) begin
                            found_q <= 1'b1;
                            row_q   <= i_row;
                            col_q   <= i_col;
                            score_q <= i_score;
                        end
                    end
                    if (i_valid && i_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_found      = found_q;
    assign o_best_row   = row_q;
    assign o_best_col   = col_q;
    assign o_best_score = score_q;
    assign o_count      = count_q;

endmodule
